// File: rtl/mac_pkg.sv
// Shared types for the systolic MAC input feeder.
package mac_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} feeder_state_e;

  typedef logic signed [DEFAULT_DATA_W-1:0] lane_t;

endpackage

// File: rtl/mac_skew_feeder_if.sv
// Input beat handshake: one N-lane A vector and one N-lane B vector per beat.
interface mac_skew_feeder_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [N*DATA_W-1:0] in_a;
  logic [N*DATA_W-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/mac_skew_line.sv
// DEPTH-stage {valid,data} delay line; DEPTH=0 is a combinational pass-through.
module mac_skew_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_valid      = in_valid;
    assign out_data       = in_valid ? in_data : '0;
  end else begin : g_regs
    logic [DEPTH-1:0] vld;
    logic [W-1:0]     dat [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else begin
        vld[0] <= in_valid;
        dat[0] <= in_valid ? in_data : '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = vld[DEPTH-1] ? dat[DEPTH-1] : '0;
  end
endmodule

// File: rtl/mac_skew_feeder.sv
// Systolic MAC input stage: beat FIFO, K_LEN-beat tile sequencer and diagonal skew.
// Optional MAC_FEEDER_PERF_EN adds the stall_cnt performance counter port.
module mac_skew_feeder
  import mac_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned K_LEN      = 7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mac_skew_feeder_if.slave    in_bus,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N*DATA_W-1:0] b_out,
  output logic [N-1:0]        lane_valid,
  output logic                busy,
  output logic                tile_done
`ifdef MAC_FEEDER_PERF_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned VW = N*DATA_W;
  localparam int unsigned CW = $clog2(K_LEN+1);
  localparam int unsigned FW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BEAT_LAST  = CW'(K_LEN-1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? N-2 : 0);

  feeder_state_e   state;
  logic [CW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;

  logic [2*VW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, empty, push, pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty           = (wr_ptr == rd_ptr);
  assign full            = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && !full;
  assign pop             = (state == STREAM) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_bus.in_a, in_bus.in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      unique case (state)
        IDLE: if (!empty) begin
          state    <= STREAM;
          beat_cnt <= '0;
          busy     <= 1'b1;
        end
        STREAM: if (pop) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == BEAT_LAST) begin
            if (N > 1) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end else begin
              state     <= DONE;
              tile_done <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Lane-0 register shared by all lanes; lane k adds k further stages behind it.
  logic          s0_valid;
  logic [VW-1:0] s0_a, s0_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else begin
      s0_valid     <= pop;
      {s0_a, s0_b} <= pop ? mem[rd_ptr[AW-1:0]] : '0;
    end
  end

  logic [N-1:0] a_vld, b_vld;

  for (genvar k = 0; k < N; k++) begin : g_lane
    mac_skew_line #(.DEPTH(k), .W(DATA_W)) u_a_line (
      .clk      (clk),
      .reset    (reset),
      .in_valid (s0_valid),
      .in_data  (s0_a[k*DATA_W +: DATA_W]),
      .out_valid(a_vld[k]),
      .out_data (a_out[k*DATA_W +: DATA_W])
    );
    mac_skew_line #(.DEPTH(k), .W(DATA_W)) u_b_line (
      .clk      (clk),
      .reset    (reset),
      .in_valid (s0_valid),
      .in_data  (s0_b[k*DATA_W +: DATA_W]),
      .out_valid(b_vld[k]),
      .out_data (b_out[k*DATA_W +: DATA_W])
    );
    assign lane_valid[k] = a_vld[k] & b_vld[k];
  end

`ifdef MAC_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == STREAM && empty && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Bench for mac_skew_feeder: random beats checked cycle by cycle against a queue-based tile model.
module tb_mac_skew_feeder;
  import mac_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = DEFAULT_DATA_W;
  localparam int unsigned K_LEN = 7;
  localparam int unsigned FD    = 4;
  localparam int unsigned VW    = N*DW;
  localparam int unsigned BW    = 2*VW;
  localparam int unsigned OW    = 3 + N + 2*VW;
  localparam logic [OW-1:0] RESET_VEC = {1'b1, {(OW-1){1'b0}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mac_skew_feeder_if #(.N(N), .DATA_W(DW)) bus ();
  logic [VW-1:0] a_out, b_out;
  logic [N-1:0]  lane_valid;
  logic          busy, tile_done;
`ifdef MAC_FEEDER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  mac_skew_feeder #(.N(N), .DATA_W(DW), .K_LEN(K_LEN), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (bus),
    .a_out     (a_out),
    .b_out     (b_out),
    .lane_valid(lane_valid),
    .busy      (busy),
    .tile_done (tile_done)
`ifdef MAC_FEEDER_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: a beat queue, a tile phase with remaining-work counters,
  // and a history of what entered lane 0 (lane k shows the entry k cycles old).
  typedef enum {M_IDLE, M_STREAM, M_FLUSH, M_DONE} mmode_e;
  logic [BW-1:0] m_q[$];
  mmode_e        m_mode;
  int            m_left, m_flush, qn;
  logic [31:0]   m_stall;
  logic          hv [N];
  logic [VW-1:0] ha [N];
  logic [VW-1:0] hb [N];
  bit            mpop, mpush;
  logic [BW-1:0] nb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_mode  = M_IDLE;
      m_left  = 0;
      m_flush = 0;
      m_stall = 0;
      for (int k = 0; k < N; k++) begin hv[k] = 0; ha[k] = '0; hb[k] = '0; end
    end else begin
      qn    = m_q.size();
      mpop  = (m_mode == M_STREAM) && (qn > 0);
      mpush = bus.in_valid && (qn < FD);
      nb    = '0;
      if (mpop)  nb = m_q.pop_front();
      if (mpush) m_q.push_back({bus.in_a, bus.in_b});
      for (int k = N-1; k > 0; k--) begin hv[k] = hv[k-1]; ha[k] = ha[k-1]; hb[k] = hb[k-1]; end
      hv[0] = mpop;
      ha[0] = nb[BW-1:VW];
      hb[0] = nb[VW-1:0];
      case (m_mode)
        M_IDLE:   if (qn > 0) begin m_mode = M_STREAM; m_left = K_LEN; end
        M_STREAM: begin
          if (mpop) begin
            m_left--;
            if (m_left == 0) begin
              if (N > 1) begin m_mode = M_FLUSH; m_flush = N-1; end
              else m_mode = M_DONE;
            end
          end else if (m_stall != 32'hFFFF_FFFF) begin
            m_stall++;
          end
        end
        M_FLUSH: begin m_flush--; if (m_flush == 0) m_mode = M_DONE; end
        M_DONE:  m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic [OW-1:0] exp_vec();
    logic [N-1:0]  lv;
    logic [VW-1:0] ea, eb;
    for (int k = 0; k < N; k++) begin
      lv[k]            = hv[k];
      ea[k*DW +: DW]   = hv[k] ? ha[k][k*DW +: DW] : '0;
      eb[k*DW +: DW]   = hv[k] ? hb[k][k*DW +: DW] : '0;
    end
    return {m_q.size() < FD, m_mode != M_IDLE, m_mode == M_DONE, lv, ea, eb};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.in_ready, busy, tile_done, lane_valid, a_out, b_out};
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int k = 0; k < 2*N; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  logic [BW-1:0] send_q[$];

  // Drive the head of send_q (or random idle data) for one edge; retire it if accepted.
  task automatic tick(input bit allow);
    bit acc;
    if (allow && send_q.size() > 0) begin
      bus.in_valid = 1'b1;
      {bus.in_a, bus.in_b} = send_q[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_a = VW'($urandom);
      bus.in_b = VW'($urandom);
    end
    acc = bus.in_valid && bus.in_ready;
    @(negedge clk);
    if (acc) void'(send_q.pop_front());
    cyc++;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    send_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs(), RESET_VEC);
    end
`ifdef MAC_FEEDER_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    for (int c = 0; c < 3; c++) begin
      tick(0);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_single_tile();
    int a0[K_LEN] = '{10, -20, 30, -40, 50, -60, 70};
    int b0[K_LEN] = '{2, 3, -4, 5, -6, 7, -8};
    int fst[N], lst[N];
    int cnt0 = 0, done_cyc = -1;
    logic [BW-1:0] v;
    do_reset();
    for (int i = 0; i < K_LEN; i++) begin
      for (int k = 0; k < N; k++) begin
        v[VW + k*DW +: DW] = DW'(a0[i] + k);
        v[k*DW +: DW]      = DW'(b0[i] + k);
      end
      send_q.push_back(v);
    end
    for (int k = 0; k < N; k++) begin fst[k] = -1; lst[k] = -1; end
    for (int c = 0; c < 25; c++) begin
      tick(1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL single_tile cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
      for (int k = 0; k < N; k++) if (lane_valid[k]) begin
        if (fst[k] < 0) fst[k] = cyc;
        lst[k] = cyc;
      end
      if (lane_valid[0]) cnt0++;
      if (tile_done) done_cyc = cyc;
    end
    checks++;
    if (cnt0 != K_LEN) begin errors++; $display("FAIL single_tile_beats: got %0d want %0d", cnt0, K_LEN); end
    for (int k = 1; k < N; k++) begin
      checks++;
      if (fst[k] - fst[0] != k || lst[k] - lst[0] != k) begin
        errors++; $display("FAIL single_tile_skew lane %0d: got %0d/%0d want %0d", k, fst[k]-fst[0], lst[k]-lst[0], k);
      end
    end
    checks++;
    if (done_cyc - lst[0] != N-1) begin
      errors++; $display("FAIL single_tile_done: got %0d want %0d", done_cyc - lst[0], N-1);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] sent[$];
    logic [2*DW-1:0] got[$];
    bit saw_full = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_q.push_back(rand_beat());
      sent.push_back(send_q[i]);
    end
    for (int c = 0; c < 50; c++) begin
      tick(1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL backpressure cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
      if (!bus.in_ready) saw_full = 1;
      if (lane_valid[0]) got.push_back({a_out[DW-1:0], b_out[DW-1:0]});
    end
    checks++;
    if (!saw_full) begin errors++; $display("FAIL backpressure_full: got in_ready never 0 want 0 at least once"); end
    checks++;
    if (got.size() != sent.size()) begin
      errors++; $display("FAIL backpressure_count: got %0d want %0d", got.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (got[i] !== {sent[i][VW +: DW], sent[i][0 +: DW]}) begin
          errors++; $display("FAIL backpressure_order beat %0d: got %h want %h", i, got[i], {sent[i][VW +: DW], sent[i][0 +: DW]});
        end
      end
    end
  endtask

  // Three idle input cycles after beat 3 drain the one-beat FIFO backlog, leaving a two-cycle bubble.
  task automatic test_bubble();
    int fst[N], lst[N];
    int cnt0 = 0, done_cyc = -1;
    do_reset();
    for (int i = 0; i < K_LEN; i++) send_q.push_back(rand_beat());
    for (int k = 0; k < N; k++) begin fst[k] = -1; lst[k] = -1; end
    for (int c = 0; c < 30; c++) begin
      tick(!(c >= 3 && c < 6));
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL bubble cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
      for (int k = 0; k < N; k++) if (lane_valid[k]) begin
        if (fst[k] < 0) fst[k] = cyc;
        lst[k] = cyc;
      end
      if (lane_valid[0]) cnt0++;
      if (tile_done) done_cyc = cyc;
    end
    checks++;
    if ((lst[0] - fst[0] + 1) - cnt0 != 2) begin
      errors++; $display("FAIL bubble_width: got %0d want 2", (lst[0] - fst[0] + 1) - cnt0);
    end
    for (int k = 1; k < N; k++) begin
      checks++;
      if (fst[k] - fst[0] != k || lst[k] - lst[0] != k) begin
        errors++; $display("FAIL bubble_skew lane %0d: got %0d/%0d want %0d", k, fst[k]-fst[0], lst[k]-lst[0], k);
      end
    end
    checks++;
    if (done_cyc - fst[0] != K_LEN + 2 - 1 + N - 1) begin
      errors++; $display("FAIL bubble_done: got %0d want %0d", done_cyc - fst[0], K_LEN + 2 - 1 + N - 1);
    end
`ifdef MAC_FEEDER_PERF_EN
    checks++;
    if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
    checks++;
    if (stall_cnt !== m_stall) begin errors++; $display("FAIL stall_cnt_model: got %0d want %0d", stall_cnt, m_stall); end
`endif
  endtask

  task automatic test_reset_mid_tile();
    int dones = 0, cnt3 = 0;
    do_reset();
    for (int i = 0; i < K_LEN; i++) send_q.push_back(rand_beat());
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL midreset_pre cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== RESET_VEC) begin
      errors++; $display("FAIL midreset_async: got %h want %h", obs(), RESET_VEC);
    end
    bus.in_valid = 1'b0;
    send_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < K_LEN; i++) send_q.push_back(rand_beat());
    for (int c = 0; c < 25; c++) begin
      tick(1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL midreset_post cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
      if (tile_done) dones++;
      if (lane_valid[N-1]) cnt3++;
    end
    checks++;
    if (dones != 1 || cnt3 != K_LEN) begin
      errors++; $display("FAIL midreset_tile: got done=%0d beats=%0d want done=1 beats=%0d", dones, cnt3, K_LEN);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, cnt0 = 0, done1 = -1, start2 = -1;
    do_reset();
    for (int i = 0; i < 2*K_LEN; i++) send_q.push_back(rand_beat());
    for (int c = 0; c < 60; c++) begin
      tick(1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %h want %h", cyc, obs(), exp_vec());
      end
      if (lane_valid[0]) begin
        cnt0++;
        if (done1 >= 0 && start2 < 0) start2 = cyc;
      end
      if (tile_done) begin
        dones++;
        if (done1 < 0) done1 = cyc;
      end
    end
    checks++;
    if (dones != 2 || cnt0 != 2*K_LEN) begin
      errors++; $display("FAIL back_to_back_tiles: got done=%0d beats=%0d want done=2 beats=%0d", dones, cnt0, 2*K_LEN);
    end
    checks++;
    if (start2 - done1 != 3) begin
      errors++; $display("FAIL back_to_back_restart: got %0d want 3", start2 - done1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    #1 reset = 1'b1;
    test_reset();
    test_single_tile();
    test_backpressure();
    test_bubble();
    test_reset_mid_tile();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
